// File: rtl/riscv_scoreboard_pkg.sv
// Shared configuration for the register scoreboard: data width,
// register count and per-register pending-counter geometry.
package riscv_scoreboard_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int CNT_W = 2;

    typedef logic [CNT_W-1:0]         cnt_t;
    typedef logic [$clog2(NREGS)-1:0] reg_idx_t;

    localparam cnt_t CNT_SAT = cnt_t'(3);

endpackage

// File: rtl/riscv_scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
// Clear wins over inc/dec; a simultaneous inc and dec cancel out.
module riscv_scoreboard_counter
    import riscv_scoreboard_pkg::*;
(
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_inc,
    input  logic i_dec,
    input  logic i_clr,
    output cnt_t o_count,
    output logic o_busy
);

    cnt_t count_q;
    cnt_t count_d;
    logic dec_eff;

    // A writeback against an idle register is dropped, never wraps.
    assign dec_eff = i_dec && (count_q != '0);

    // Next-state: clear, else net increment or net decrement.
    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc && !dec_eff && (count_q != CNT_SAT)) begin
            count_d = count_q + cnt_t'(1);
        end else if (dec_eff && !i_inc) begin
            count_d = count_q - cnt_t'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
    assign o_busy  = (count_q != '0);

endmodule

// File: rtl/riscv_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counters,
// RAW/saturation stall and optional writeback bypass (RISCV_SCOREBOARD_BYPASS_EN).
module riscv_scoreboard
    import riscv_scoreboard_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_issue_valid,
    input  logic            i_issue_rs1_used,
    input  logic            i_issue_rs2_used,
    input  reg_idx_t        i_issue_rs1_addr,
    input  reg_idx_t        i_issue_rs2_addr,
    input  logic            i_issue_rd_wen,
    input  reg_idx_t        i_issue_rd_addr,
    output logic            o_issue_stall,
    input  logic            i_wb_valid,
    input  reg_idx_t        i_wb_rd_addr,
    input  logic [XLEN-1:0] i_wb_rd_data,
    input  logic            i_flush,
    output logic [NREGS-1:0] o_busy_vec,
    output logic            o_fwd_rs1_hit,
    output logic            o_fwd_rs2_hit,
    output logic [XLEN-1:0] o_fwd_rs1_data,
    output logic [XLEN-1:0] o_fwd_rs2_data
);

    cnt_t [NREGS-1:0] cnt_w;
    logic             rs1_byp_w;
    logic             rs2_byp_w;
    logic             rs1_haz_w;
    logic             rs2_haz_w;
    logic             rd_sat_w;
    logic             issue_acc_w;

    // x0 is hardwired, so it is never tracked.
    assign cnt_w[0]      = '0;
    assign o_busy_vec[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_cnt
        logic inc_w;
        logic dec_w;

        assign inc_w = issue_acc_w && i_issue_rd_wen
                    && (i_issue_rd_addr == reg_idx_t'(g));
        assign dec_w = i_wb_valid
                    && (i_wb_rd_addr == reg_idx_t'(g));

        riscv_scoreboard_counter u_cnt (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_inc   (inc_w),
            .i_dec   (dec_w),
            .i_clr   (i_flush),
            .o_count (cnt_w[g]),
            .o_busy  (o_busy_vec[g])
        );
    end

`ifdef RISCV_SCOREBOARD_BYPASS_EN
    // The last outstanding writer retiring now can feed the source directly.
    assign rs1_byp_w = i_wb_valid
                    && (i_issue_rs1_addr != '0)
                    && (i_wb_rd_addr == i_issue_rs1_addr)
                    && (cnt_w[i_issue_rs1_addr] == cnt_t'(1));
    assign rs2_byp_w = i_wb_valid
                    && (i_issue_rs2_addr != '0)
                    && (i_wb_rd_addr == i_issue_rs2_addr)
                    && (cnt_w[i_issue_rs2_addr] == cnt_t'(1));

    assign o_fwd_rs1_hit  = rs1_byp_w;
    assign o_fwd_rs2_hit  = rs2_byp_w;
    assign o_fwd_rs1_data = rs1_byp_w ? i_wb_rd_data : '0;
    assign o_fwd_rs2_data = rs2_byp_w ? i_wb_rd_data : '0;
`else
    logic unused_wb_data;

    assign unused_wb_data = ^i_wb_rd_data;

    assign rs1_byp_w      = 1'b0;
    assign rs2_byp_w      = 1'b0;
    assign o_fwd_rs1_hit  = 1'b0;
    assign o_fwd_rs2_hit  = 1'b0;
    assign o_fwd_rs1_data = '0;
    assign o_fwd_rs2_data = '0;
`endif

    assign rs1_haz_w = i_issue_rs1_used
                    && (i_issue_rs1_addr != '0)
                    && (cnt_w[i_issue_rs1_addr] != '0)
                    && !rs1_byp_w;
    assign rs2_haz_w = i_issue_rs2_used
                    && (i_issue_rs2_addr != '0)
                    && (cnt_w[i_issue_rs2_addr] != '0)
                    && !rs2_byp_w;

    // A saturated destination has no room for another writer.
    assign rd_sat_w = i_issue_rd_wen
                   && (i_issue_rd_addr != '0)
                   && (cnt_w[i_issue_rd_addr] == CNT_SAT);

    assign o_issue_stall = i_issue_valid
                        && (rs1_haz_w || rs2_haz_w || rd_sat_w);
    assign issue_acc_w   = i_issue_valid && !o_issue_stall;

endmodule

// File: tb/tb_riscv_scoreboard.sv
// Self-checking bench for riscv_scoreboard: directed scenarios plus
// randomized traffic against a per-register pending-count model.
module tb_riscv_scoreboard;
    import riscv_scoreboard_pkg::*;

`ifdef RISCV_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            i_clk;
    logic            i_rstn;
    logic            i_issue_valid;
    logic            i_issue_rs1_used;
    logic            i_issue_rs2_used;
    logic [4:0]      i_issue_rs1_addr;
    logic [4:0]      i_issue_rs2_addr;
    logic            i_issue_rd_wen;
    logic [4:0]      i_issue_rd_addr;
    logic            o_issue_stall;
    logic            i_wb_valid;
    logic [4:0]      i_wb_rd_addr;
    logic [XLEN-1:0] i_wb_rd_data;
    logic            i_flush;
    logic [31:0]     o_busy_vec;
    logic            o_fwd_rs1_hit;
    logic            o_fwd_rs2_hit;
    logic [XLEN-1:0] o_fwd_rs1_data;
    logic [XLEN-1:0] o_fwd_rs2_data;

    int passed;
    int total;
    int m_cnt [32];

    riscv_scoreboard dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_issue_valid    (i_issue_valid),
        .i_issue_rs1_used (i_issue_rs1_used),
        .i_issue_rs2_used (i_issue_rs2_used),
        .i_issue_rs1_addr (i_issue_rs1_addr),
        .i_issue_rs2_addr (i_issue_rs2_addr),
        .i_issue_rd_wen   (i_issue_rd_wen),
        .i_issue_rd_addr  (i_issue_rd_addr),
        .o_issue_stall    (o_issue_stall),
        .i_wb_valid       (i_wb_valid),
        .i_wb_rd_addr     (i_wb_rd_addr),
        .i_wb_rd_data     (i_wb_rd_data),
        .i_flush          (i_flush),
        .o_busy_vec       (o_busy_vec),
        .o_fwd_rs1_hit    (o_fwd_rs1_hit),
        .o_fwd_rs2_hit    (o_fwd_rs2_hit),
        .o_fwd_rs1_data   (o_fwd_rs1_data),
        .o_fwd_rs2_data   (o_fwd_rs2_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        i_issue_valid    = 1'b0;
        i_issue_rs1_used = 1'b0;
        i_issue_rs2_used = 1'b0;
        i_issue_rs1_addr = '0;
        i_issue_rs2_addr = '0;
        i_issue_rd_wen   = 1'b0;
        i_issue_rd_addr  = '0;
        i_wb_valid       = 1'b0;
        i_wb_rd_addr     = '0;
        i_wb_rd_data     = '0;
        i_flush          = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        i_rstn           = 1'b0;
        i_issue_valid    = 1'b1;
        i_issue_rs1_used = 1'b1;
        i_issue_rs1_addr = 5'd5;
        i_issue_rd_wen   = 1'b1;
        i_issue_rd_addr  = 5'd5;
        i_wb_valid       = 1'b1;
        i_wb_rd_addr     = 5'd5;
        i_wb_rd_data     = 32'hA5A5_5A5A;
        tick();
        total++;
        if (o_busy_vec !== 32'h0)
            $display("FAIL rst_busy: got %h want 0", o_busy_vec);
        else passed++;
        total++;
        if (o_issue_stall !== 1'b0)
            $display("FAIL rst_stall: got %0b want 0", o_issue_stall);
        else passed++;
        total++;
        if ({o_fwd_rs1_hit, o_fwd_rs2_hit} !== 2'b00
            || o_fwd_rs1_data !== '0 || o_fwd_rs2_data !== '0)
            $display("FAIL rst_fwd: got hit=%b%b d1=%h d2=%h want 0",
                     o_fwd_rs1_hit, o_fwd_rs2_hit,
                     o_fwd_rs1_data, o_fwd_rs2_data);
        else passed++;
        do_reset();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd6;
        tick();
        tick();
        total++;
        if (o_busy_vec[6] !== 1'b1)
            $display("FAIL rst_pre_busy: got %0b want 1", o_busy_vec[6]);
        else passed++;
        idle();
        #2;
        i_rstn           = 1'b0;
        i_issue_valid    = 1'b1;
        i_issue_rs1_used = 1'b1;
        i_issue_rs1_addr = 5'd6;
        #1;
        total++;
        if (o_busy_vec !== 32'h0 || o_issue_stall !== 1'b0)
            $display("FAIL rst_async: got busy=%h stall=%0b want 0/0",
                     o_busy_vec, o_issue_stall);
        else passed++;
        tick();
        idle();
        i_rstn       = 1'b1;
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd6;
        tick();
        idle();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd6;
        tick();
        idle();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd6;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec[6] !== 1'b0)
            $display("FAIL rst_post_wb: got %0b want 0", o_busy_vec[6]);
        else passed++;
    endtask

    task automatic test_dependency();
        do_reset();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd5;
        #1;
        total++;
        if (o_issue_stall !== 1'b0)
            $display("FAIL dep_first: got %0b want 0", o_issue_stall);
        else passed++;
        tick();
        idle();
        i_issue_valid    = 1'b1;
        i_issue_rs1_used = 1'b1;
        i_issue_rs1_addr = 5'd5;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++;
            if (o_issue_stall !== 1'b1 || o_busy_vec[5] !== 1'b1)
                $display("FAIL dep_hold: got stall=%0b busy=%0b want 1/1",
                         o_issue_stall, o_busy_vec[5]);
            else passed++;
            tick();
        end
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd5;
        i_wb_rd_data = 32'h1234_5678;
        #1;
        total++;
        if (o_issue_stall !== !BYP)
            $display("FAIL dep_wb_cycle: got %0b want %0b",
                     o_issue_stall, !BYP);
        else passed++;
        tick();
        i_wb_valid = 1'b0;
        #1;
        total++;
        if (o_issue_stall !== 1'b0 || o_busy_vec[5] !== 1'b0)
            $display("FAIL dep_release: got stall=%0b busy=%0b want 0/0",
                     o_issue_stall, o_busy_vec[5]);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (o_issue_stall !== 1'b0)
                $display("FAIL sat_fill%0d: got %0b want 0",
                         k, o_issue_stall);
            else passed++;
            tick();
        end
        total++;
        if (o_issue_stall !== 1'b1 || o_busy_vec[7] !== 1'b1)
            $display("FAIL sat_full: got stall=%0b busy=%0b want 1/1",
                     o_issue_stall, o_busy_vec[7]);
        else passed++;
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd7;
        #1;
        total++;
        if (o_issue_stall !== 1'b1)
            $display("FAIL sat_wb_same: got %0b want 1", o_issue_stall);
        else passed++;
        tick();
        i_wb_valid = 1'b0;
        #1;
        total++;
        if (o_issue_stall !== 1'b0)
            $display("FAIL sat_release: got %0b want 0", o_issue_stall);
        else passed++;
        tick();
        idle();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (o_busy_vec[7] !== (k < 2))
                $display("FAIL sat_drain%0d: got %0b want %0b",
                         k, o_busy_vec[7], (k < 2));
            else passed++;
        end
        idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd9;
        tick();
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd9;
        #1;
        total++;
        if (o_issue_stall !== 1'b0)
            $display("FAIL same_stall: got %0b want 0", o_issue_stall);
        else passed++;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec[9] !== 1'b1)
            $display("FAIL same_busy: got %0b want 1", o_busy_vec[9]);
        else passed++;
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd9;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec[9] !== 1'b0)
            $display("FAIL same_count1: got %0b want 0", o_busy_vec[9]);
        else passed++;
    endtask

    task automatic test_bypass();
        do_reset();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd3;
        tick();
        idle();
        i_issue_valid    = 1'b1;
        i_issue_rs2_used = 1'b1;
        i_issue_rs2_addr = 5'd3;
        i_wb_valid       = 1'b1;
        i_wb_rd_addr     = 5'd3;
        i_wb_rd_data     = 32'hDEADBEEF;
        #1;
        total++;
        if (o_issue_stall !== !BYP)
            $display("FAIL byp_stall: got %0b want %0b",
                     o_issue_stall, !BYP);
        else passed++;
        total++;
        if (o_fwd_rs2_hit !== BYP
            || o_fwd_rs2_data !== (BYP ? 32'hDEADBEEF : 32'h0))
            $display("FAIL byp_rs2: got hit=%0b data=%h want %0b",
                     o_fwd_rs2_hit, o_fwd_rs2_data, BYP);
        else passed++;
        total++;
        if (o_fwd_rs1_hit !== 1'b0 || o_fwd_rs1_data !== '0)
            $display("FAIL byp_rs1: got hit=%0b data=%h want 0/0",
                     o_fwd_rs1_hit, o_fwd_rs1_data);
        else passed++;
        tick();
        idle();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd3;
        tick();
        tick();
        idle();
        i_issue_valid    = 1'b1;
        i_issue_rs2_used = 1'b1;
        i_issue_rs2_addr = 5'd3;
        i_wb_valid       = 1'b1;
        i_wb_rd_addr     = 5'd3;
        i_wb_rd_data     = 32'hCAFE_F00D;
        #1;
        total++;
        if (o_issue_stall !== 1'b1 || o_fwd_rs2_hit !== 1'b0)
            $display("FAIL byp_cnt2: got stall=%0b hit=%0b want 1/0",
                     o_issue_stall, o_fwd_rs2_hit);
        else passed++;
        tick();
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        i_issue_valid  = 1'b1;
        i_issue_rd_wen = 1'b1;
        i_issue_rd_addr = 5'd1;
        tick();
        i_issue_rd_addr = 5'd2;
        tick();
        i_issue_rd_addr = 5'd31;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec !== 32'h8000_0006)
            $display("FAIL fl_pre: got %h want 80000006", o_busy_vec);
        else passed++;
        i_flush          = 1'b1;
        i_issue_valid    = 1'b1;
        i_issue_rs1_used = 1'b1;
        i_issue_rs1_addr = 5'd1;
        i_issue_rd_wen   = 1'b1;
        i_issue_rd_addr  = 5'd4;
        i_wb_valid       = 1'b1;
        i_wb_rd_addr     = 5'd31;
        #1;
        total++;
        if (o_issue_stall !== 1'b1)
            $display("FAIL fl_stall: got %0b want 1", o_issue_stall);
        else passed++;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec !== 32'h0)
            $display("FAIL fl_clear: got %h want 0", o_busy_vec);
        else passed++;
        i_wb_valid   = 1'b1;
        i_wb_rd_addr = 5'd2;
        tick();
        idle();
        i_issue_valid   = 1'b1;
        i_issue_rd_wen  = 1'b1;
        i_issue_rd_addr = 5'd2;
        tick();
        idle();
        #1;
        total++;
        if (o_busy_vec !== 32'h4)
            $display("FAIL fl_no_underflow: got %h want 4", o_busy_vec);
        else passed++;
    endtask

    task automatic test_zero_regs();
        do_reset();
        i_issue_valid    = 1'b1;
        i_issue_rs1_used = 1'b1;
        i_issue_rs2_used = 1'b1;
        i_issue_rd_wen   = 1'b1;
        i_wb_valid       = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            total++;
            if (o_issue_stall !== 1'b0 || o_busy_vec !== 32'h0)
                $display("FAIL zero%0d: got stall=%0b busy=%h want 0/0",
                         k, o_issue_stall, o_busy_vec);
            else passed++;
            tick();
        end
        idle();
    endtask

    function automatic logic [4:0] pick();
        int r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_random();
        logic        b1;
        logic        b2;
        logic        e_stall;
        logic        acc;
        logic [31:0] e_busy;
        bit          inc;
        bit          dec;
        do_reset();
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        for (int c = 0; c < 400; c++) begin
            i_issue_valid    = ($urandom_range(0, 3) != 0);
            i_issue_rs1_used = 1'($urandom_range(0, 1));
            i_issue_rs2_used = 1'($urandom_range(0, 1));
            i_issue_rs1_addr = pick();
            i_issue_rs2_addr = pick();
            i_issue_rd_wen   = ($urandom_range(0, 3) != 0);
            i_issue_rd_addr  = pick();
            i_wb_valid       = ($urandom_range(0, 2) == 0);
            i_wb_rd_addr     = pick();
            i_wb_rd_data     = $urandom;
            i_flush          = ($urandom_range(0, 40) == 0);
            if (i_wb_valid && i_wb_rd_addr == i_issue_rd_addr
                && m_cnt[i_wb_rd_addr] == 0)
                i_wb_valid = 1'b0;
            b1 = BYP && i_wb_valid && i_issue_rs1_addr != 0
              && i_wb_rd_addr == i_issue_rs1_addr
              && m_cnt[i_issue_rs1_addr] == 1;
            b2 = BYP && i_wb_valid && i_issue_rs2_addr != 0
              && i_wb_rd_addr == i_issue_rs2_addr
              && m_cnt[i_issue_rs2_addr] == 1;
            e_stall = i_issue_valid && (
                (i_issue_rs1_used && i_issue_rs1_addr != 0
                 && m_cnt[i_issue_rs1_addr] > 0 && !b1)
             || (i_issue_rs2_used && i_issue_rs2_addr != 0
                 && m_cnt[i_issue_rs2_addr] > 0 && !b2)
             || (i_issue_rd_wen && i_issue_rd_addr != 0
                 && m_cnt[i_issue_rd_addr] == 3));
            e_busy = '0;
            for (int r = 1; r < 32; r++) e_busy[r] = (m_cnt[r] > 0);
            #1;
            total++;
            if (o_issue_stall !== e_stall)
                $display("FAIL rnd_stall c%0d: got %0b want %0b",
                         c, o_issue_stall, e_stall);
            else passed++;
            total++;
            if (o_busy_vec !== e_busy)
                $display("FAIL rnd_busy c%0d: got %h want %h",
                         c, o_busy_vec, e_busy);
            else passed++;
            total++;
            if (o_fwd_rs1_hit !== b1
                || o_fwd_rs1_data !== (b1 ? i_wb_rd_data : '0))
                $display("FAIL rnd_fwd1 c%0d: got %0b/%h want %0b",
                         c, o_fwd_rs1_hit, o_fwd_rs1_data, b1);
            else passed++;
            total++;
            if (o_fwd_rs2_hit !== b2
                || o_fwd_rs2_data !== (b2 ? i_wb_rd_data : '0))
                $display("FAIL rnd_fwd2 c%0d: got %0b/%h want %0b",
                         c, o_fwd_rs2_hit, o_fwd_rs2_data, b2);
            else passed++;
            acc = i_issue_valid && !e_stall;
            for (int r = 1; r < 32; r++) begin
                if (i_flush) begin
                    m_cnt[r] = 0;
                end else begin
                    inc = acc && i_issue_rd_wen && i_issue_rd_addr == r;
                    dec = i_wb_valid && i_wb_rd_addr == r && m_cnt[r] > 0;
                    if (inc && !dec) m_cnt[r] = m_cnt[r] + 1;
                    else if (dec && !inc) m_cnt[r] = m_cnt[r] - 1;
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        i_rstn = 1'b0;
        idle();
        test_reset();
        test_dependency();
        test_saturate();
        test_same_cycle();
        test_bypass();
        test_flush();
        test_zero_regs();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
